// File: rtl/window_ctrl_pkg.sv
// Shared types for the window scan controller: state encodings and their width.
package window_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE         = 3'd0,
    S_FILL         = 3'd1,
    S_EN_FIRST_COL = 3'd2,
    S_EN_COL       = 3'd3,
    S_ROW_WAIT     = 3'd4,
    S_FRAME_WAIT   = 3'd5
  } state_e;

endpackage

// File: rtl/window_scan_controller_gap_timer.sv
// Loadable down-counter shared by the fill, row-gap and frame-gap waits.
// Holds at zero; o_zero flags the final cycle of a wait.
module gap_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/window_scan_controller.sv
// Window-enable sequencer for a KSIZE x KSIZE sliding-window unit fed from BRAM line buffers.
// Optional performance counters are enabled with `define WINDOW_SCAN_PERF_CNT_EN.
module window_scan_controller
  import window_ctrl_pkg::*;
#(
  parameter int KSIZE     = 7,
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 16,
  parameter int FILL_LAT  = 71,
  parameter int ROW_GAP   = 5,
  parameter int FRAME_GAP = 59,
  parameter int CNT_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_continuous,
  input  logic               i_stall,
  input  logic               i_abort,
  output logic [STATE_W-1:0] o_state,
  output logic               o_enable,
  output logic               o_first_col,
  output logic [CNT_W-1:0]   o_col,
  output logic [CNT_W-1:0]   o_row,
  output logic               o_busy,
  output logic               o_frame_done
`ifdef WINDOW_SCAN_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   o_frame_cnt,
  output logic [CNT_W-1:0]   o_stall_cnt
`endif
);

  localparam int OUT_W = IMG_W - KSIZE + 1;
  localparam int OUT_H = IMG_H - KSIZE + 1;

  localparam longint CNT_LIM = longint'(1) << CNT_W;
  localparam bit PARAMS_OK = (KSIZE >= 3) && (KSIZE % 2 == 1) &&
                             (IMG_W >= KSIZE) && (IMG_H >= KSIZE) &&
                             (FILL_LAT >= 0) && (ROW_GAP >= 0) && (FRAME_GAP >= 0) &&
                             (CNT_W >= 1) && (CNT_W <= 32) &&
                             (longint'(FILL_LAT) < CNT_LIM) && (longint'(ROW_GAP) < CNT_LIM) &&
                             (longint'(FRAME_GAP) < CNT_LIM) &&
                             (longint'(OUT_W) < CNT_LIM) && (longint'(OUT_H) < CNT_LIM);

  if (!PARAMS_OK) begin : g_bad_params
    $error("window_scan_controller: illegal parameter combination");
  end

  // Timer reload values are N-1 so a wait of N lasts exactly N cycles.
  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'((FILL_LAT  > 0) ? FILL_LAT  - 1 : 0);
  localparam logic [CNT_W-1:0] ROW_LD   = CNT_W'((ROW_GAP   > 0) ? ROW_GAP   - 1 : 0);
  localparam logic [CNT_W-1:0] FRAME_LD = CNT_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(OUT_H - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] w_col_nxt;
  logic [CNT_W-1:0] w_row_nxt;
  logic             w_tmr_clr;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  logic             w_row_end;
  logic             w_frame_done;

  gap_timer #(
    .CNT_W(CNT_W)
  ) u_gap_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_tmr_clr   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;
    w_row_end   = 1'b0;

    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_col_nxt   = '0;
      w_row_nxt   = '0;
      w_tmr_clr   = 1'b1;
    end else if (!i_stall) begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (FILL_LAT == 0) begin
              w_state_nxt = S_EN_FIRST_COL;
            end else begin
              w_state_nxt = S_FILL;
              w_tmr_load  = 1'b1;
              w_tmr_val   = FILL_LD;
            end
          end
        end
        S_FILL: begin
          if (w_tmr_zero) w_state_nxt = S_EN_FIRST_COL;
          else            w_tmr_dec   = 1'b1;
        end
        S_EN_FIRST_COL: begin
          w_col_nxt = '0;
          if (OUT_W > 1) begin
            w_state_nxt = S_EN_COL;
            w_col_nxt   = CNT_W'(1);
          end else begin
            w_row_end = 1'b1;
          end
        end
        S_EN_COL: begin
          if (r_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_end = 1'b1;
          end else begin
            w_col_nxt = r_col + CNT_W'(1);
          end
        end
        S_ROW_WAIT: begin
          if (w_tmr_zero) w_state_nxt = S_EN_FIRST_COL;
          else            w_tmr_dec   = 1'b1;
        end
        S_FRAME_WAIT: begin
          if (w_tmr_zero) begin
            if (i_continuous) w_state_nxt = S_EN_FIRST_COL;
            else              w_state_nxt = S_IDLE;
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      // End of an output row: either the frame is complete or the next row waits its gap.
      if (w_row_end) begin
        if (r_row == ROW_LAST) begin
          w_row_nxt = '0;
          if (FRAME_GAP == 0) begin
            if (i_continuous) w_state_nxt = S_EN_FIRST_COL;
            else              w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FRAME_WAIT;
            w_tmr_load  = 1'b1;
            w_tmr_val   = FRAME_LD;
          end
        end else begin
          w_row_nxt = r_row + CNT_W'(1);
          if (ROW_GAP == 0) begin
            w_state_nxt = S_EN_FIRST_COL;
          end else begin
            w_state_nxt = S_ROW_WAIT;
            w_tmr_load  = 1'b1;
            w_tmr_val   = ROW_LD;
          end
        end
      end
    end
  end

  // w_row_end is only raised on an unstalled, non-aborted cycle, so the pulse inherits that gating.
  assign w_frame_done = w_row_end && (r_row == ROW_LAST);

  assign o_state      = r_state;
  assign o_enable     = ((r_state == S_EN_FIRST_COL) || (r_state == S_EN_COL)) && !i_stall;
  assign o_first_col  = (r_state == S_EN_FIRST_COL) && !i_stall;
  assign o_frame_done = w_frame_done;
  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_busy       = (r_state != S_IDLE);

`ifdef WINDOW_SCAN_PERF_CNT_EN
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Cleared by reset only; abort leaves the statistics intact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (i_stall && (r_state != S_IDLE) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_window_scan_controller.sv
// Self-checking bench: a per-cycle expected trace is built from the frame geometry
// (fill, rows of enables, gaps) and compared against two DUT configurations.
module tb_window_scan_controller;

  localparam int KS = 3;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int OW = IW - KS + 1;
  localparam int OH = IH - KS + 1;
  localparam int CW = 16;

  localparam int FILL_A = 4;
  localparam int RGAP_A = 2;
  localparam int FGAP_A = 3;
  localparam int FILL_B = 0;
  localparam int RGAP_B = 0;
  localparam int FGAP_B = 3;

  typedef struct packed {
    logic          en;
    logic          fc;
    logic          fd;
    logic          busy;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
  } obs_t;

  logic clk;
  logic rst_n;

  logic          start_a, cont_a, stall_a, abort_a;
  logic [2:0]    state_a;
  logic          en_a, fc_a, fd_a, busy_a;
  logic [CW-1:0] col_a, row_a;

  logic          start_b, cont_b, stall_b, abort_b;
  logic [2:0]    state_b;
  logic          en_b, fc_b, fd_b, busy_b;
  logic [CW-1:0] col_b, row_b;

`ifdef WINDOW_SCAN_PERF_CNT_EN
  logic [CW-1:0] fcnt_a, scnt_a, fcnt_b, scnt_b;
`endif

  int   n_cmp;
  int   n_bad;
  obs_t exp_q[$];

  window_scan_controller #(
    .KSIZE(KS), .IMG_W(IW), .IMG_H(IH),
    .FILL_LAT(FILL_A), .ROW_GAP(RGAP_A), .FRAME_GAP(FGAP_A), .CNT_W(CW)
  ) dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start_a),
    .i_continuous (cont_a),
    .i_stall      (stall_a),
    .i_abort      (abort_a),
    .o_state      (state_a),
    .o_enable     (en_a),
    .o_first_col  (fc_a),
    .o_col        (col_a),
    .o_row        (row_a),
    .o_busy       (busy_a),
    .o_frame_done (fd_a)
`ifdef WINDOW_SCAN_PERF_CNT_EN
    ,
    .o_frame_cnt  (fcnt_a),
    .o_stall_cnt  (scnt_a)
`endif
  );

  window_scan_controller #(
    .KSIZE(KS), .IMG_W(IW), .IMG_H(IH),
    .FILL_LAT(FILL_B), .ROW_GAP(RGAP_B), .FRAME_GAP(FGAP_B), .CNT_W(CW)
  ) dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start_b),
    .i_continuous (cont_b),
    .i_stall      (stall_b),
    .i_abort      (abort_b),
    .o_state      (state_b),
    .o_enable     (en_b),
    .o_first_col  (fc_b),
    .o_col        (col_b),
    .o_row        (row_b),
    .o_busy       (busy_b),
    .o_frame_done (fd_b)
`ifdef WINDOW_SCAN_PERF_CNT_EN
    ,
    .o_frame_cnt  (fcnt_b),
    .o_stall_cnt  (scnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic obs_t mk(bit en, bit fc, bit fd, bit busy, int col, int row);
    obs_t o;
    o.en   = en;
    o.fc   = fc;
    o.fd   = fd;
    o.busy = busy;
    o.col  = CW'(col);
    o.row  = CW'(row);
    return o;
  endfunction

  // One frame as seen cycle by cycle when never stalled: fill, rows of windows, gaps.
  function automatic void model_frame(int fill, int rgap, int fgap);
    for (int i = 0; i < fill; i++) exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++)
        exp_q.push_back(mk(1, c == 0, (r == OH-1) && (c == OW-1), 1, c, r));
      if (r < OH-1)
        for (int g = 0; g < rgap; g++) exp_q.push_back(mk(0, 0, 0, 1, 0, r + 1));
    end
    for (int g = 0; g < fgap; g++) exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
  endfunction

  function automatic obs_t stalled_view(obs_t head);
    return mk(0, 0, 0, head.busy, int'(head.col), int'(head.row));
  endfunction

  // ---------------- drive / sample ----------------
  task automatic tick_a(output obs_t o);
    @(negedge clk);
    o = '{en: en_a, fc: fc_a, fd: fd_a, busy: busy_a, col: col_a, row: row_a};
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(output obs_t o);
    @(negedge clk);
    o = '{en: en_b, fc: fc_b, fd: fd_b, busy: busy_b, col: col_b, row: row_b};
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t idle_o;
    idle_o = mk(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({en_a, fc_a, fd_a, busy_a, col_a, row_a} !== idle_o) begin
      n_bad++;
      $display("FAIL reset_outputs_a: got %h expected %h", {en_a, fc_a, fd_a, busy_a, col_a, row_a}, idle_o);
    end
    n_cmp++;
    if (state_a !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_state_a: got %0d expected 0", state_a);
    end
    n_cmp++;
    if ({en_b, fc_b, fd_b, busy_b, col_b, row_b, state_b} !== {idle_o, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_b: got %h expected %h", {en_b, fc_b, fd_b, busy_b, col_b, row_b, state_b}, {idle_o, 3'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    obs_t o, e;
    int   cyc, n_en, n_fd, first_en;
    exp_q.delete();
    model_frame(FILL_A, RGAP_A, FGAP_A);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    cyc = 0; n_en = 0; n_fd = 0; first_en = -1;
    cont_a = 1'b0;
    start_a = 1'b1;
    tick_a(o);
    start_a = 1'b0;
    while (exp_q.size() > 0) begin
      tick_a(o);
      cyc++;
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL single_frame cycle %0d: got %p expected %p", cyc, o, e);
      end
      if (o.en) begin
        n_en++;
        if (first_en < 0) first_en = cyc;
      end
      if (o.fd) n_fd++;
    end
    n_cmp++;
    if (first_en !== FILL_A + 1) begin
      n_bad++;
      $display("FAIL single_first_enable: got cycle %0d expected %0d", first_en, FILL_A + 1);
    end
    n_cmp++;
    if (n_en !== OW*OH) begin
      n_bad++;
      $display("FAIL single_enable_total: got %0d expected %0d", n_en, OW*OH);
    end
    n_cmp++;
    if (n_fd !== 1) begin
      n_bad++;
      $display("FAIL single_frame_done_count: got %0d expected 1", n_fd);
    end
  endtask

  task automatic test_continuous();
    obs_t o, e;
    int   l2, cyc, n_en, n_fd;
    exp_q.delete();
    model_frame(FILL_A, RGAP_A, FGAP_A);
    model_frame(0, RGAP_A, FGAP_A);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    l2 = OW*OH + (OH-1)*RGAP_A + FGAP_A;
    cyc = 0; n_en = 0; n_fd = 0;
    cont_a = 1'b1;
    start_a = 1'b1;
    tick_a(o);
    start_a = 1'b0;
    while (exp_q.size() > 0) begin
      cont_a = (exp_q.size() > l2 + 1);
      tick_a(o);
      cyc++;
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL continuous cycle %0d: got %p expected %p", cyc, o, e);
      end
      if (o.en) n_en++;
      if (o.fd) n_fd++;
    end
    cont_a = 1'b0;
    n_cmp++;
    if ({n_en, n_fd} !== {2*OW*OH, 2}) begin
      n_bad++;
      $display("FAIL continuous_totals: got enables=%0d done=%0d expected %0d and 2", n_en, n_fd, 2*OW*OH);
    end
  endtask

  task automatic test_stall_fixed();
    obs_t o, e;
    int   cyc, base_len, stall_left, row1_en;
    exp_q.delete();
    model_frame(FILL_A, RGAP_A, FGAP_A);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    base_len = exp_q.size();
    cyc = 0; stall_left = 3; row1_en = 0;
    cont_a = 1'b0;
    start_a = 1'b1;
    tick_a(o);
    start_a = 1'b0;
    while (exp_q.size() > 0) begin
      stall_a = (stall_left > 0) && exp_q[0].en && (exp_q[0].row == 1) && (exp_q[0].col == 2);
      if (stall_a) stall_left--;
      tick_a(o);
      cyc++;
      if (stall_a) e = stalled_view(exp_q[0]);
      else         e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL stall_fixed cycle %0d stall=%0b: got %p expected %p", cyc, stall_a, o, e);
      end
      if (o.en && (o.row == 1)) row1_en++;
    end
    stall_a = 1'b0;
    n_cmp++;
    if (row1_en !== OW) begin
      n_bad++;
      $display("FAIL stall_row1_enables: got %0d expected %0d", row1_en, OW);
    end
    n_cmp++;
    if (cyc !== base_len + 3) begin
      n_bad++;
      $display("FAIL stall_frame_length: got %0d expected %0d", cyc, base_len + 3);
    end
  endtask

  task automatic test_random_stall();
    obs_t o, e;
    int   l2, cyc, n_en, n_fd;
    exp_q.delete();
    model_frame(FILL_A, RGAP_A, FGAP_A);
    model_frame(0, RGAP_A, FGAP_A);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    l2 = OW*OH + (OH-1)*RGAP_A + FGAP_A;
    cyc = 0; n_en = 0; n_fd = 0;
    cont_a = 1'b1;
    start_a = 1'b1;
    tick_a(o);
    start_a = 1'b0;
    while (exp_q.size() > 0) begin
      cont_a  = (exp_q.size() > l2 + 1);
      stall_a = ($urandom_range(0, 2) == 0);
      tick_a(o);
      cyc++;
      if (stall_a) e = stalled_view(exp_q[0]);
      else         e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL random_stall cycle %0d stall=%0b: got %p expected %p", cyc, stall_a, o, e);
      end
      if (o.en) n_en++;
      if (o.fd) n_fd++;
    end
    stall_a = 1'b0;
    cont_a  = 1'b0;
    n_cmp++;
    if ({n_en, n_fd} !== {2*OW*OH, 2}) begin
      n_bad++;
      $display("FAIL random_stall_totals: got enables=%0d done=%0d expected %0d and 2", n_en, n_fd, 2*OW*OH);
    end
  endtask

  task automatic test_abort();
    obs_t o, e;
    int   cyc, n_fd, first_en, budget;
    exp_q.delete();
    for (int i = 0; i < FILL_A; i++) exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
    for (int c = 0; c < OW; c++) exp_q.push_back(mk(1, c == 0, 0, 1, c, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 1));
    cyc = 0; n_fd = 0;
    cont_a = 1'b0;
    start_a = 1'b1;
    tick_a(o);
    start_a = 1'b0;
    while (exp_q.size() > 0) begin
      abort_a = (exp_q.size() == 1);
      tick_a(o);
      cyc++;
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL abort_run cycle %0d: got %p expected %p", cyc, o, e);
      end
      if (o.fd) n_fd++;
    end
    abort_a = 1'b0;
    tick_a(o);
    n_cmp++;
    if ({o, state_a} !== {mk(0, 0, 0, 0, 0, 0), 3'd0}) begin
      n_bad++;
      $display("FAIL abort_to_idle: got %p state=%0d expected idle state 0", o, state_a);
    end
    n_cmp++;
    if (n_fd !== 0) begin
      n_bad++;
      $display("FAIL abort_no_frame_done: got %0d pulses expected 0", n_fd);
    end
    start_a = 1'b1;
    tick_a(o);
    start_a = 1'b0;
    first_en = -1;
    for (int i = 1; i <= 40; i++) begin
      tick_a(o);
      if (o.en) begin
        first_en = i;
        break;
      end
    end
    n_cmp++;
    if (first_en !== FILL_A + 1) begin
      n_bad++;
      $display("FAIL abort_restart_latency: got %0d expected %0d", first_en, FILL_A + 1);
    end
    budget = 0;
    while (busy_a && budget < 400) begin
      tick_a(o);
      budget++;
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_restart_finish: busy=%0b after %0d cycles expected 0", busy_a, budget);
    end
  endtask

  task automatic test_zero_gaps();
    obs_t o, e;
    int   cyc, n_en;
    int   fc_at[$];
    exp_q.delete();
    model_frame(FILL_B, RGAP_B, FGAP_B);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    cyc = 0; n_en = 0;
    cont_b = 1'b0;
    start_b = 1'b1;
    tick_b(o);
    start_b = 1'b0;
    while (exp_q.size() > 0) begin
      tick_b(o);
      cyc++;
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL zero_gaps cycle %0d: got %p expected %p", cyc, o, e);
      end
      if (o.en) begin
        n_en++;
        if (o.fc) fc_at.push_back(n_en);
      end
    end
    n_cmp++;
    if (fc_at.size() !== OH) begin
      n_bad++;
      $display("FAIL zero_gaps_first_col_count: got %0d expected %0d", fc_at.size(), OH);
    end else begin
      for (int k = 0; k < OH; k++) begin
        n_cmp++;
        if (fc_at[k] !== 1 + k*OW) begin
          n_bad++;
          $display("FAIL zero_gaps_first_col_pos %0d: got enable %0d expected %0d", k, fc_at[k], 1 + k*OW);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t o;
    int   first_en, budget, woke;
    cont_a = 1'b1;
    start_a = 1'b1;
    tick_a(o);
    start_a = 1'b0;
    for (int i = 0; i < FILL_A + 2; i++) tick_a(o);
    n_cmp++;
    if (state_a !== 3'd3) begin
      n_bad++;
      $display("FAIL reset_mid_precondition: state %0d expected 3", state_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({state_a, en_a, fc_a, fd_a, busy_a, col_a, row_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_async: got state=%0d en=%0b fc=%0b fd=%0b busy=%0b col=%0d row=%0d expected all 0",
               state_a, en_a, fc_a, fd_a, busy_a, col_a, row_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    woke = 0;
    for (int i = 0; i < 6; i++) begin
      tick_a(o);
      if (o.busy || o.en) woke++;
    end
    n_cmp++;
    if (woke !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_stale_continuous: busy in %0d cycles expected 0", woke);
    end
    start_a = 1'b1;
    tick_a(o);
    start_a = 1'b0;
    cont_a  = 1'b0;
    first_en = -1;
    for (int i = 1; i <= 40; i++) begin
      tick_a(o);
      if (o.en) begin
        first_en = i;
        break;
      end
    end
    n_cmp++;
    if (first_en !== FILL_A + 1) begin
      n_bad++;
      $display("FAIL reset_mid_restart_latency: got %0d expected %0d", first_en, FILL_A + 1);
    end
    budget = 0;
    while (busy_a && budget < 400) begin
      tick_a(o);
      budget++;
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_finish: busy=%0b after %0d cycles expected 0", busy_a, budget);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; stall_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; cont_b = 1'b0; stall_b = 1'b0; abort_b = 1'b0;

    test_reset();
    test_single_frame();
    test_continuous();
    test_stall_fixed();
    test_random_stall();
    test_abort();
    test_zero_gaps();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
